key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a level change (legal range 1..2^CNT_W-1).
REQ-002 SHALL have parameter LONG_CYCLES, default 12000000, pressed-hold cycles before long-press report.
REQ-003 SHALL have parameter CNT_W, default 24, width of debounce/hold counters (must hold both cycle parameters).
REQ-004 SHALL have parameter INV_BTN, default 0; 1 means key_i low = pressed.
REQ-005 Ports: clk  in  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-006 Ports: rst  in  1  asynchronous active-high reset.
REQ-007 Ports: key_i  in  1  raw asynchronous button pin.
REQ-008 Ports: key_o  out  1  debounced level, 1 = pressed.
REQ-009 Ports: press_o  out  1  one-cycle pulse on accepted press.
REQ-010 Ports: release_o  out  1  one-cycle pulse on accepted release.
REQ-011 Ports: long_o  out  1  one-cycle pulse on long press.
REQ-012 Ports: press_cnt_o  out  8  count of accepted presses.

Function
REQ-013 key_i SHALL pass a 2-flop synchronizer, then XOR INV_BTN, giving key_s (1 = pressed).
REQ-014 FSM states SHALL be RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 RELEASED: key_s=1 -> PRESS_WAIT, cnt=1; else hold, cnt=0.
REQ-016 PRESS_WAIT: key_s=0 -> RELEASED, cnt=0 (glitch rejected, no pulse); key_s=1 and cnt==DEBOUNCE_CYCLES -> PRESSED; else cnt+1.
REQ-017 PRESSED: key_s=0 -> RELEASE_WAIT, cnt=1; else hold.
REQ-018 RELEASE_WAIT: key_s=1 -> PRESSED, cnt=0 (no pulse); key_s=0 and cnt==DEBOUNCE_CYCLES -> RELEASED; else cnt+1.
REQ-019 All outputs SHALL be registered; press_o/release_o high exactly the one cycle after the accepting transition edge; key_o=1 in PRESSED and RELEASE_WAIT.
REQ-020 Latency: press_o SHALL assert after DEBOUNCE_CYCLES+3 clk edges, counting the first edge that samples key_i pressed; release symmetric.
REQ-021 press_cnt_o SHALL increment on every press_o, wrapping 255 -> 0.
REQ-022 press_o and release_o SHALL never be high in the same cycle.

Reset
REQ-023 rst SHALL asynchronously force state RELEASED, cnt=0, hold counter 0, synchronizer flops to the unpressed level (INV_BTN), all outputs 0, press_cnt_o=0.
REQ-024 Key held through reset release SHALL be debounced from scratch and produce a normal press_o; reset mid-PRESSED SHALL emit no release_o.

Configuration
REQ-025 Macro KEY_DEBOUNCE_LONGPRESS_EN defined: hold counter counts cycles in PRESSED/RELEASE_WAIT, saturates, pulses long_o once when it reaches LONG_CYCLES, clears on entry to RELEASED.
REQ-026 Macro undefined: no hold counter synthesized, long_o tied 0; all other behaviour identical.

Structure
REQ-027 Package key_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (async-reset, reset-value parameter); everything else in key_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, INV_BTN=0)
REQ-029 key_i held 1 from edge 0 -> press_o single pulse after edge 7, key_o=1, press_cnt_o=1.
REQ-030 key_i pulses 1 for 3 cycles then 0 -> no press_o, key_o stays 0, press_cnt_o=0.
REQ-031 press accepted, key_i 0 for 2 cycles then 1 -> no release_o, key_o stays 1; then 0 held -> release_o after 7 edges.
REQ-032 256 clean presses -> press_cnt_o wraps to 0; exactly 256 press_o and 256 release_o.
REQ-033 With KEY_DEBOUNCE_LONGPRESS_EN, key held 40 cycles after press_o -> exactly one long_o, 20 cycles after press_o; without macro long_o always 0.
REQ-034 rst asserted mid-PRESS_WAIT and mid-PRESSED with key held -> outputs 0 immediately; after release of rst, press_o after 7 edges.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - FSM state encoding and default parameter constants for key_debounce
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_LONG_CYCLES     = 12000000;
    localparam int DEF_CNT_W           = 24;
    localparam int DEF_INV_BTN         = 0;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous reset to a configurable level
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the asynchronous input a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with press/release pulses; long-press behind KEY_DEBOUNCE_LONGPRESS_EN
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int INV_BTN         = DEF_INV_BTN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic       key_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic [7:0] press_cnt_o
);

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic   INV     = (INV_BTN != 0);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Reject cycle parameters that the CNT_W-wide counters cannot hold.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CNT_MAX ||
        LONG_CYCLES < 1 || LONG_CYCLES > CNT_MAX) begin : g_bad_cycles
        $error("key_debounce: cycle parameters out of range for CNT_W");
    end

    logic             key_sync;
    logic             key_s;
    key_state_t       state;
    key_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_acc;
    logic             release_acc;

    // Synchronizer idles at the unpressed pin level so reset never looks like a press.
    sync_2ff #(
        .RST_VAL (INV)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_i),
        .q   (key_sync)
    );

    assign key_s = key_sync ^ INV;

    // State and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a level change must persist DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (key_s) begin
                    next_state = PRESS_WAIT;
                    cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    next_state = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == DEB_MAX) begin
                    next_state = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    next_state = RELEASE_WAIT;
                    cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    next_state = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DEB_MAX) begin
                    next_state = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + 1'b1;
                end
            end
            default: begin
                next_state = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    assign press_acc   = (state == PRESS_WAIT)   && (next_state == PRESSED);
    assign release_acc = (state == RELEASE_WAIT) && (next_state == RELEASED);

    // Registered outputs reflect the transition taken on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_o       <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            press_cnt_o <= 8'd0;
        end else begin
            key_o     <= (next_state == PRESSED) || (next_state == RELEASE_WAIT);
            press_o   <= press_acc;
            release_o <= release_acc;
            if (press_acc) begin
                press_cnt_o <= press_cnt_o + 8'd1;
            end
        end
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold_cnt;
    logic             long_q;

    // Hold time accumulates across release glitches and saturates so long_o fires once per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (next_state == RELEASED) begin
                hold_cnt <= '0;
            end else if (((state == PRESSED) || (state == RELEASE_WAIT)) && (hold_cnt != LONG_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
                long_q   <= (hold_cnt == (LONG_MAX - 1'b1));
            end
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed table-driven bench for key_debounce (D=4, LONG=20, INV_BTN=0)
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       key_o;
    logic       press_o;
    logic       release_o;
    logic       long_o;
    logic [7:0] press_cnt_o;

    int total = 0;
    int passed = 0;
    int both_high = 0;
    int long_total = 0;

    typedef struct {
        logic       key;
        logic       ko;
        logic       p;
        logic       r;
        logic [7:0] c;
    } vec_t;

    vec_t vq[$];

    key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .CNT_W           (24),
        .INV_BTN         (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_i       (key),
        .key_o       (key_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .long_o      (long_o),
        .press_cnt_o (press_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_o && release_o) both_high++;
        if (long_o) long_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input int n, input logic k, input logic ko, input logic p,
                       input logic r, input logic [7:0] c);
        vec_t v;
        v.key = k; v.ko = ko; v.p = p; v.r = r; v.c = c;
        repeat (n) vq.push_back(v);
    endtask

    task automatic wait_press(output int steps);
        steps = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (press_o) begin
                steps = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int  steps;
    int  pc;
    int  rc;
    int  lc;
    int  lpos;
    int  rel_seen;

    initial begin
        // press from reset: accepted on the 7th edge after key rises
        add(6, 1, 0, 0, 0, 8'd0);
        add(1, 1, 1, 1, 0, 8'd1);
        add(3, 1, 1, 0, 0, 8'd1);
        // clean release, symmetric latency
        add(6, 0, 1, 0, 0, 8'd1);
        add(1, 0, 0, 0, 1, 8'd1);
        add(3, 0, 0, 0, 0, 8'd1);
        // 3-cycle glitch rejected
        add(3, 1, 0, 0, 0, 8'd1);
        add(7, 0, 0, 0, 0, 8'd1);
        // 4-cycle pulse (one short of acceptance) rejected
        add(4, 1, 0, 0, 0, 8'd1);
        add(7, 0, 0, 0, 0, 8'd1);
        // 5-cycle pulse is the shortest accepted press
        add(5, 1, 0, 0, 0, 8'd1);
        add(1, 0, 0, 0, 0, 8'd1);
        add(1, 0, 1, 1, 0, 8'd2);
        add(4, 0, 1, 0, 0, 8'd2);
        add(1, 0, 0, 0, 1, 8'd2);
        add(2, 0, 0, 0, 0, 8'd2);
        // press, 2-cycle release glitch ignored, then real release
        add(6, 1, 0, 0, 0, 8'd2);
        add(1, 1, 1, 1, 0, 8'd3);
        add(2, 1, 1, 0, 0, 8'd3);
        add(2, 0, 1, 0, 0, 8'd3);
        add(6, 1, 1, 0, 0, 8'd3);
        add(6, 0, 1, 0, 0, 8'd3);
        add(1, 0, 0, 0, 1, 8'd3);
        add(2, 0, 0, 0, 0, 8'd3);

        // reset state
        step();
        step();
        #1;
        check("reset_outputs", {key_o, press_o, release_o, long_o, press_cnt_o}, 32'd0);
        rst = 1'b0;

        foreach (vq[i]) begin
            key = vq[i].key;
            step();
            check($sformatf("vec[%0d]", i), {key_o, press_o, release_o, press_cnt_o},
                  {vq[i].ko, vq[i].p, vq[i].r, vq[i].c});
        end

        // 256 clean presses wrap the counter
        pulse_reset();
        pc = 0;
        rc = 0;
        for (int p = 0; p < 256; p++) begin
            key = 1'b1;
            repeat (10) begin
                step();
                if (press_o) pc++;
                if (release_o) rc++;
            end
            key = 1'b0;
            repeat (10) begin
                step();
                if (press_o) pc++;
                if (release_o) rc++;
            end
            if (p == 254) check("press_cnt_255", press_cnt_o, 32'd255);
        end
        check("press_cnt_wrap", press_cnt_o, 32'd0);
        check("press_pulses_256", pc, 32'd256);
        check("release_pulses_256", rc, 32'd256);

        // long press window
        pulse_reset();
        key = 1'b1;
        wait_press(steps);
        check("long_press_latency", steps, 32'd7);
        lc = 0;
        lpos = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (long_o) begin
                lc++;
                lpos = k;
            end
        end
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        check("long_count", lc, 32'd1);
        check("long_position", lpos, 32'd20);
`else
        check("long_count", lc, 32'd0);
        check("long_never", long_total, 32'd0);
`endif
        key = 1'b0;
        repeat (10) step();

        // reset in PRESS_WAIT after one accepted press
        pulse_reset();
        key = 1'b1;
        repeat (8) step();
        key = 1'b0;
        repeat (10) step();
        check("pre_rst_cnt", press_cnt_o, 32'd1);
        key = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("rst_pw_outputs", {key_o, press_o, release_o, long_o, press_cnt_o}, 32'd0);
        step();
        step();
        rst = 1'b0;
        wait_press(steps);
        check("rst_pw_latency", steps, 32'd7);
        check("rst_pw_cnt", press_cnt_o, 32'd1);

        // reset in PRESSED with key held: no release pulse, fresh press
        repeat (3) step();
        check("pressed_key_o", key_o, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_pr_outputs", {key_o, press_o, release_o, long_o, press_cnt_o}, 32'd0);
        step();
        step();
        rst = 1'b0;
        rel_seen = 0;
        steps = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (release_o) rel_seen++;
            if (press_o) begin
                steps = i;
                break;
            end
        end
        check("rst_pr_latency", steps, 32'd7);
        check("rst_pr_no_release", rel_seen, 32'd0);
        check("rst_pr_key_o", key_o, 32'd1);

        check("press_release_exclusive", both_high, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
